// File: rtl/sad_unit_if.sv
// sad_unit_if: job/operand handshake and result status bundle between an operand source and sad_unit
interface sad_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int ACC_W = WIDTH + CNT_W
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] result;
  logic             ovf;
  modport master (output start, len, in_valid, a_in, b_in, input in_ready, busy, done, result, ovf);
  modport slave  (input start, len, in_valid, a_in, b_in, output in_ready, busy, done, result, ovf);
endinterface

// File: rtl/sad_unit.sv
// sad_unit: sequential sum of |A-B| over len pairs; define SAD_SAT_EN to saturate instead of wrap on overflow
module sad_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int ACC_W = WIDTH + CNT_W
) (
  input logic     clk,
  input logic     reset,
  sad_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH, CHK, NEG, ACC, DONE} state_t;
  state_t           r_state;
  logic [WIDTH:0]   r_d;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_result;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_nxt;
  assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(r_d[WIDTH-1:0]);
`ifdef SAD_SAT_EN
  assign w_acc_nxt = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
`else
  assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif
  assign bus.in_ready = r_in_ready;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.ovf      = r_ovf;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_d        <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_cnt  <= bus.len;
          r_acc  <= '0;
          r_ovf  <= 1'b0;
          r_busy <= 1'b1;
          if (bus.len == '0) begin
            r_state  <= DONE;
            r_done   <= 1'b1;
            r_result <= '0;
          end else begin
            r_state    <= FETCH;
            r_in_ready <= 1'b1;
          end
        end
        FETCH: if (bus.in_valid) begin
          r_d        <= {1'b0, bus.a_in} - {1'b0, bus.b_in};
          r_in_ready <= 1'b0;
          r_state    <= CHK;
        end
        CHK: r_state <= r_d[WIDTH] ? NEG : ACC;
        NEG: begin
          r_d     <= -r_d;
          r_state <= ACC;
        end
        ACC: begin
          r_acc <= w_acc_nxt;
          r_ovf <= r_ovf | w_sum[ACC_W];
          r_cnt <= r_cnt - CNT_W'(1);
          // result is loaded on entry to DONE so it is already valid while done is high
          if (r_cnt == CNT_W'(1)) begin
            r_state  <= DONE;
            r_done   <= 1'b1;
            r_result <= w_acc_nxt;
          end else begin
            r_state    <= FETCH;
            r_in_ready <= 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sad_unit.sv
// tb_sad_unit: directed jobs against a sum-of-|A-B| model, with literal pins on latency and results
module tb_sad_unit;
  localparam int W = 8;
  localparam int C = 8;
  localparam int AW = 9;
  localparam longint MAXV = (64'd1 << AW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  sad_unit_if #(.WIDTH(W), .CNT_W(C), .ACC_W(AW)) bus();
  sad_unit #(.WIDTH(W), .CNT_W(C), .ACC_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int failures = 0;
  int pa [8];
  int pb [8];
  longint exp_res = 0;
  logic exp_ovf = 1'b0;
  int rdy_cnt = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  longint last_res = 0;
  logic last_ovf = 1'b0;
  int lat;
  int dc;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic void model(input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) s += (pa[i] > pb[i]) ? pa[i] - pb[i] : pb[i] - pa[i];
    exp_ovf = (s > MAXV);
`ifdef SAD_SAT_EN
    exp_res = (s > MAXV) ? MAXV : s;
`else
    exp_res = s % (MAXV + 1);
`endif
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.in_ready) rdy_cnt++;
      chk("ready_only_in_fetch", bus.in_ready & ~(bus.busy & ~bus.done), 0);
      if (bus.done) begin
        done_cnt++;
        chk("result", bus.result, exp_res);
        chk("ovf", bus.ovf, exp_ovf);
        chk("done_one_cycle", prev_done, 0);
        chk("busy_in_done", bus.busy, 1);
        last_res = bus.result;
        last_ovf = bus.ovf;
      end
      prev_done = bus.done;
    end
  end

  task automatic start_job(input int n);
    bus.start = 1'b1;
    bus.len = C'(n);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic put_pair(input int a, input int b, input int gap);
    int n = 0;
    while (!bus.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      tmo("in_ready_wait");
      return;
    end
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_in = W'(a);
    bus.b_in = W'(b);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!bus.done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) tmo("done_wait");
  endtask

  task automatic run_job(input int n, input int gap, output int l);
    model(n);
    rdy_cnt = 0;
    start_job(n);
    for (int i = 0; i < n; i++) put_pair(pa[i], pb[i], gap);
    wait_done(l);
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.len = '0;
    bus.in_valid = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_ovf", bus.ovf, 0);
    reset = 1'b0;
    @(negedge clk);
    pa[0] = 9; pb[0] = 4;
    run_job(1, 0, lat);
    chk("t1_latency", lat, 3);
    chk("t1_result", last_res, 5);
    chk("t1_ovf", last_ovf, 0);
    chk("t1_ready_cycles", rdy_cnt, 1);
    chk("t1_idle_busy", bus.busy, 0);
    pa[0] = 4; pb[0] = 9;
    run_job(1, 0, lat);
    chk("t2_latency", lat, 4);
    chk("t2_result", last_res, 5);
    pa[0] = 0; pb[0] = 255; pa[1] = 255; pb[1] = 0; pa[2] = 7; pb[2] = 7;
    run_job(3, 2, lat);
    chk("t3_result", last_res, 510);
    chk("t3_ovf", last_ovf, 0);
    chk("t3_ready_cycles", rdy_cnt, 9);
    chk("t3_latency_equal", lat, 3);
    run_job(0, 0, lat);
    chk("t4_latency", lat, 1);
    chk("t4_result", last_res, 0);
    chk("t4_ready_cycles", rdy_cnt, 0);
    pa[0] = 10; pb[0] = 3; pa[1] = 1; pb[1] = 1;
    model(2);
    start_job(2);
    put_pair(pa[0], pb[0], 0);
    bus.start = 1'b1;
    bus.len = C'(7);
    @(negedge clk);
    bus.start = 1'b0;
    put_pair(pa[1], pb[1], 0);
    wait_done(lat);
    @(negedge clk);
    chk("t4_ignored_start_result", last_res, 7);
    chk("t4_ignored_start_latency", lat, 3);
    pa[0] = 255; pb[0] = 0; pa[1] = 255; pb[1] = 0; pa[2] = 255; pb[2] = 0;
    run_job(3, 0, lat);
`ifdef SAD_SAT_EN
    chk("t5_result", last_res, 511);
`else
    chk("t5_result", last_res, 253);
`endif
    chk("t5_ovf", last_ovf, 1);
    pa[0] = 5; pb[0] = 1; pa[1] = 2; pb[1] = 8;
    start_job(4);
    put_pair(pa[0], pb[0], 0);
    put_pair(pa[1], pb[1], 0);
    dc = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_in_ready", bus.in_ready, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_result", bus.result, 0);
    chk("t6_ovf", bus.ovf, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_no_done", done_cnt, dc);
    chk("t6_idle", bus.busy, 0);
    pa[0] = 3; pb[0] = 1;
    run_job(1, 0, lat);
    chk("t6_new_result", last_res, 2);
    chk("t6_new_ovf", last_ovf, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
